// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: 8:1 data mux driven by a round-robin burst scheduler.
// A requester is granted for up to BURST_LEN accepted beats. The grant ends
// early if that requester drops its request. One idle cycle always separates
// two grants.
// Optional feature macro: MUX_SCHED_STATS_EN adds the o_beat_cnt statistic.
module mux8_rr_sched #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_req,
  input  logic [7:0]  i_i,
  input  logic        i_out_ready,
  output logic [2:0]  o_s,
  output logic [7:0]  o_gnt,
  output logic        o_out,
  output logic        o_out_valid
`ifdef MUX_SCHED_STATS_EN
  ,
  output logic [15:0] o_beat_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_s, w_s_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [3:0] r_bcnt, w_bcnt_nxt;

  logic [2:0] w_sel;
  logic       w_found;
  logic       w_vld;
  logic       w_accept;
  logic       w_last;

  // Find the first requester at or above ptr, wrapping from 7 to 0.
  always_comb begin
    w_sel   = 3'd0;
    w_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!w_found && i_req[r_ptr + 3'(k)]) begin
        w_sel   = r_ptr + 3'(k);
        w_found = 1'b1;
      end
    end
  end

  // Offer a beat only while the granted requester keeps its request up.
  assign w_vld    = (r_state == GRANT) && i_req[r_s];
  assign w_accept = w_vld && i_out_ready;
  assign w_last   = (r_bcnt + 4'd1) == 4'(BURST_LEN);

  // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_bcnt_nxt  = r_bcnt;
    case (r_state)
      IDLE: begin
        w_gnt_nxt = 8'h00;
        if (w_found) begin
          w_state_nxt = GRANT;
          w_s_nxt     = w_sel;
          w_gnt_nxt   = 8'h01 << w_sel;
          w_bcnt_nxt  = 4'd0;
        end
      end
      GRANT: begin
        if (!i_req[r_s] || (w_accept && w_last)) begin
          // Release the grant, and give the requester after s top priority.
          w_state_nxt = IDLE;
          w_gnt_nxt   = 8'h00;
          w_ptr_nxt   = r_s + 3'd1;
          w_bcnt_nxt  = w_accept ? r_bcnt + 4'd1 : r_bcnt;
        end else if (w_accept) begin
          w_bcnt_nxt = r_bcnt + 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Register the scheduler state. Reset abandons any burst that is in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_s     <= 3'd0;
      r_gnt   <= 8'h00;
      r_ptr   <= 3'd0;
      r_bcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  assign o_s         = r_s;
  assign o_gnt       = r_gnt;
  assign o_out_valid = w_vld;
  assign o_out       = w_vld & i_i[r_s];

`ifdef MUX_SCHED_STATS_EN
  logic [15:0] r_beat_cnt;

  // Count accepted beats. The count saturates, and only reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_beat_cnt <= 16'h0000;
    else if (w_accept && (r_beat_cnt != 16'hFFFF))
      r_beat_cnt <= r_beat_cnt + 16'd1;
  end

  assign o_beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched. Expected outputs go on a queue when a vector is
// driven, and come off it when the outputs are sampled mid-cycle.
// Define MUX_SCHED_STATS_EN to also cover the beat statistic.
module tb_mux8_rr_sched;

  typedef struct {
    logic [7:0] req;
    logic [7:0] i;
    logic       rdy;
    logic [2:0] s;
    logic [7:0] gnt;
    logic       out;
    logic       vld;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] din = 8'h00;
  logic       rdy = 1'b0;
  logic [2:0] s;
  logic [7:0] gnt;
  logic       out;
  logic       vld;
`ifdef MUX_SCHED_STATS_EN
  logic [15:0] beat_cnt;
`endif

  int total = 0;
  int bad = 0;
  vec_t sb[$];
  vec_t tbl[13];

  mux8_rr_sched #(.BURST_LEN(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_i         (din),
    .i_out_ready (rdy),
    .o_s         (s),
    .o_gnt       (gnt),
    .o_out       (out),
    .o_out_valid (vld)
`ifdef MUX_SCHED_STATS_EN
    ,
    .o_beat_cnt  (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [7:0] rq, logic [7:0] d, logic r,
                              logic [2:0] es, logic [7:0] eg, logic eo, logic ev);
    vec_t v;
    v.req = rq; v.i = d; v.rdy = r; v.s = es; v.gnt = eg; v.out = eo; v.vld = ev;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pop the oldest expectation and compare it with the outputs as they are now.
  task automatic chk(input string nm);
    vec_t e;
    if (sb.size() == 0) begin
      cmp({nm, ".sb_empty"}, 16'd1, 16'd0);
      return;
    end
    e = sb.pop_front();
    cmp({nm, ".s"},   16'(s),   16'(e.s));
    cmp({nm, ".gnt"}, 16'(gnt), 16'(e.gnt));
    cmp({nm, ".out"}, 16'(out), 16'(e.out));
    cmp({nm, ".vld"}, 16'(vld), 16'(e.vld));
  endtask

  // Drive one cycle of inputs, queue the expected outputs, then sample mid-cycle.
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    req = v.req; din = v.i; rdy = v.rdy;
    sb.push_back(v);
    #1 chk(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 8'h00; rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Single requester 2: one burst, a bubble, a regrant, a stall and a
    // change on another request line, then a handover to requester 3.
    tbl[0]  = mk(8'h04, 8'h04, 1, 3'd0, 8'h00, 0, 0);
    tbl[1]  = mk(8'h04, 8'h04, 1, 3'd2, 8'h04, 1, 1);
    tbl[2]  = mk(8'h04, 8'h04, 1, 3'd2, 8'h04, 1, 1);
    tbl[3]  = mk(8'h04, 8'h04, 1, 3'd2, 8'h04, 1, 1);
    tbl[4]  = mk(8'h04, 8'h04, 1, 3'd2, 8'h04, 1, 1);
    tbl[5]  = mk(8'h04, 8'h04, 1, 3'd2, 8'h00, 0, 0);
    tbl[6]  = mk(8'h04, 8'h00, 1, 3'd2, 8'h04, 0, 1);
    tbl[7]  = mk(8'h0C, 8'h04, 1, 3'd2, 8'h04, 1, 1);
    tbl[8]  = mk(8'hFF, 8'h04, 0, 3'd2, 8'h04, 1, 1);
    tbl[9]  = mk(8'hFF, 8'h04, 1, 3'd2, 8'h04, 1, 1);
    tbl[10] = mk(8'h04, 8'h04, 1, 3'd2, 8'h04, 1, 1);
    tbl[11] = mk(8'h0C, 8'h04, 1, 3'd2, 8'h00, 0, 0);
    tbl[12] = mk(8'h08, 8'h08, 1, 3'd3, 8'h08, 1, 1);

    // Outputs while reset is held.
    #2;
    cmp("rst.s", 16'(s), 16'd0);
    cmp("rst.gnt", 16'(gnt), 16'h0);
    cmp("rst.vld", 16'(vld), 16'd0);
    cmp("rst.out", 16'(out), 16'd0);
    do_reset();

    for (int k = 0; k < 13; k++) step(tbl[k], $sformatf("tbl%0d", k));

    // All eight requesting: grants go 0..7 then back to 0, four beats each,
    // with one bubble after every grant.
    do_reset();
    step(mk(8'hFF, 8'hAA, 1, 3'd0, 8'h00, 0, 0), "rr.idle");
    for (int g = 0; g < 9; g++) begin
      logic [7:0] dd;
      logic [2:0] gi;
      dd = 8'hAA;
      gi = 3'(g);
      for (int b = 0; b < 4; b++)
        step(mk(8'hFF, 8'hAA, 1, gi, 8'h01 << gi, dd[gi], 1), $sformatf("rr.g%0d.b%0d", g, b));
      step(mk(8'hFF, 8'hAA, 1, gi, 8'h00, 0, 0), $sformatf("rr.bub%0d", g));
    end

    // Wrap and skip: an early release of 5 leaves ptr at 6. The next grant
    // goes to 0, and only after that to 5.
    do_reset();
    step(mk(8'h20, 8'hFF, 1, 3'd0, 8'h00, 0, 0), "ws.idle");
    step(mk(8'h01, 8'hFF, 1, 3'd5, 8'h20, 0, 0), "ws.rel5");
    step(mk(8'h21, 8'hFF, 1, 3'd5, 8'h00, 0, 0), "ws.bub");
    for (int b = 0; b < 4; b++)
      step(mk(8'h21, 8'hFF, 1, 3'd0, 8'h01, 1, 1), $sformatf("ws.g0.b%0d", b));
    step(mk(8'h21, 8'hFF, 1, 3'd0, 8'h00, 0, 0), "ws.bub2");
    step(mk(8'h21, 8'hFF, 1, 3'd5, 8'h20, 1, 1), "ws.g5");

    // Stall grant 3 for 10 cycles. No beats count, so three more beats still
    // leave the grant open. Then release early, and ptr moves on to 4.
    do_reset();
    step(mk(8'h08, 8'h08, 0, 3'd0, 8'h00, 0, 0), "st.idle");
    for (int c = 0; c < 10; c++)
      step(mk(8'h08, 8'h08, 0, 3'd3, 8'h08, 1, 1), $sformatf("st.stall%0d", c));
    for (int b = 0; b < 3; b++)
      step(mk(8'h08, 8'h08, 1, 3'd3, 8'h08, 1, 1), $sformatf("st.beat%0d", b));
    step(mk(8'h00, 8'h08, 1, 3'd3, 8'h08, 0, 0), "st.drop");
    step(mk(8'hFF, 8'hFF, 1, 3'd3, 8'h00, 0, 0), "st.idle2");
    step(mk(8'hFF, 8'hFF, 1, 3'd4, 8'h10, 1, 1), "st.g4");

    // Asynchronous reset between edges in the middle of a burst.
    do_reset();
    step(mk(8'h02, 8'h02, 1, 3'd0, 8'h00, 0, 0), "ar.idle");
    step(mk(8'h02, 8'h02, 1, 3'd1, 8'h02, 1, 1), "ar.g1");
    rst_n = 1'b0;
    #1;
    cmp("ar.s", 16'(s), 16'd0);
    cmp("ar.gnt", 16'(gnt), 16'h0);
    cmp("ar.vld", 16'(vld), 16'd0);
    cmp("ar.out", 16'(out), 16'd0);
    rst_n = 1'b1; req = 8'h80; din = 8'h80;
    #1;
    cmp("ar.rel.gnt", 16'(gnt), 16'h0);
    step(mk(8'h80, 8'h80, 1, 3'd7, 8'h80, 1, 1), "ar.g7");

`ifdef MUX_SCHED_STATS_EN
    // Ten accepted beats: two full bursts, then two beats of a third.
    do_reset();
    cmp("st0.cnt", beat_cnt, 16'd0);
    step(mk(8'h01, 8'h01, 1, 3'd0, 8'h00, 0, 0), "bc.idle");
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < ((g == 2) ? 2 : 4); b++)
        step(mk(8'h01, 8'h01, 1, 3'd0, 8'h01, 1, 1), $sformatf("bc.g%0d.b%0d", g, b));
      if (g < 2) step(mk(8'h01, 8'h01, 1, 3'd0, 8'h00, 0, 0), $sformatf("bc.bub%0d", g));
    end
    step(mk(8'h01, 8'h01, 0, 3'd0, 8'h01, 1, 1), "bc.stall");
    cmp("bc.cnt10", beat_cnt, 16'd10);
    force dut.r_beat_cnt = 16'hFFFE;
    #1 release dut.r_beat_cnt;
    step(mk(8'h01, 8'h01, 1, 3'd0, 8'h01, 1, 1), "bc.sat0");
    step(mk(8'h01, 8'h01, 1, 3'd0, 8'h01, 1, 1), "bc.sat1");
    step(mk(8'h01, 8'h01, 1, 3'd0, 8'h00, 0, 0), "bc.satbub");
    step(mk(8'h01, 8'h01, 1, 3'd0, 8'h01, 1, 1), "bc.sat2");
    step(mk(8'h01, 8'h01, 0, 3'd0, 8'h01, 1, 1), "bc.satstall");
    cmp("bc.sat", beat_cnt, 16'hFFFF);
`endif

    if (sb.size() != 0) cmp("sb.leftover", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
